// File: rtl/key_debounce_pulser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce_pulser_pkg
//  Description : Shared definitions for the directional key debounce/pulser:
//                key index constants, hold-FSM state encodings, default
//                timing constants and a counter-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package key_debounce_pulser_pkg;

    // Key bit positions within key_n / KeysHeld / the pending vector.
    localparam int c_KEY_LEFT  = 0;
    localparam int c_KEY_UP    = 1;
    localparam int c_KEY_DOWN  = 2;
    localparam int c_KEY_RIGHT = 3;

    // Per-key hold FSM state encodings.
    localparam int          c_HOLD_W      = 2;
    localparam logic [1:0]  c_HOLD_IDLE   = 2'd0;
    localparam logic [1:0]  c_HOLD_DELAY  = 2'd1;
    localparam logic [1:0]  c_HOLD_REPEAT = 2'd2;

    // Default timing, expressed in clock cycles at 50 MHz.
    localparam int c_DEF_DEBOUNCE_CYCLES      = 1000000;   // 20 ms
    localparam int c_DEF_REPEAT_DELAY_CYCLES  = 25000000;  // 500 ms
    localparam int c_DEF_REPEAT_PERIOD_CYCLES = 10000000;  // 200 ms

    // Width of a counter that must hold values 0 .. maxCount-1. The counters
    // clear on reaching maxCount-1, so they never need to represent maxCount.
    function automatic int cntWidth(input int maxCount);
        return (maxCount > 1) ? $clog2(maxCount) : 1;
    endfunction

endpackage : key_debounce_pulser_pkg
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : One key's 2-flop synchronizer, debounce counter and
//                released->pressed edge detect.
//  Ports       : clock      - sole clock, rising edge
//                resetApp   - synchronous active-high reset
//                keyRaw_n   - raw push-button level, active-low, async
//                keyHeld    - registered debounced pressed state (1=pressed)
//                pressEvent - one-cycle pulse in the cycle after the
//                             debounced state flips to pressed
//  Revision    : 1.0  initial release
// ============================================================================
module key_debounce
    import key_debounce_pulser_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic resetApp,
    input  logic keyRaw_n,
    output logic keyHeld,
    output logic pressEvent
);

    localparam int                 c_CNT_W    = cntWidth(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    // The level is inverted on entry so that every flop here uses
    // 1 = pressed, and the reset value 0 means released throughout.
    logic               r_sync1;
    logic               r_sync2;
    logic               r_held;
    logic               r_press;
    logic [c_CNT_W-1:0] r_count;
    logic               w_differ;

    assign w_differ = (r_sync2 != r_held);

    always_ff @(posedge clock) begin
        if (resetApp) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_held  <= 1'b0;
            r_press <= 1'b0;
            r_count <= '0;
        end else begin
            r_sync1 <= ~keyRaw_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (!w_differ) begin
                // Any return to the accepted level restarts the stability count.
                r_count <= '0;
            end else if (r_count == c_CNT_LAST) begin
                r_held  <= r_sync2;
                r_count <= '0;
                // Only a released->pressed flip is an event.
                r_press <= r_sync2;
            end else begin
                r_count <= r_count + c_CNT_W'(1);
            end
        end
    end

    assign keyHeld    = r_held;
    assign pressEvent = r_press;

endmodule : key_debounce
`default_nettype wire

// File: rtl/key_debounce_pulser.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce_pulser
//  Description : Debounces NUM_KEYS active-low directional keys, generates a
//                press pulse plus timed auto-repeat pulses per held key, and
//                serialises them onto one-hot move pulses (Left>Up>Down>Right).
//  Ports       : clock     - sole clock, rising edge
//                resetApp  - synchronous active-high reset
//                key_n     - raw key levels, active-low, async to clock
//                KeyLeft/KeyUp/KeyDown/KeyRight - registered one-cycle move
//                            pulses, at most one high per cycle
//                KeysHeld  - registered debounced pressed state per key
//  Revision    : 1.0  initial release
// ============================================================================
module key_debounce_pulser
    import key_debounce_pulser_pkg::*;
#(
    parameter int NUM_KEYS             = 4,
    parameter int DEBOUNCE_CYCLES      = c_DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY_CYCLES  = c_DEF_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_PERIOD_CYCLES = c_DEF_REPEAT_PERIOD_CYCLES
) (
    input  logic                clock,
    input  logic                resetApp,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic                KeyLeft,
    output logic                KeyUp,
    output logic                KeyDown,
    output logic                KeyRight,
    output logic [NUM_KEYS-1:0] KeysHeld
);

    // One shared repeat counter width covers both the delay and the period.
    localparam int c_REP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                               REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int                 c_REP_W       = cntWidth(c_REP_MAX);
    localparam logic [c_REP_W-1:0] c_DELAY_LAST  = c_REP_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [c_REP_W-1:0] c_PERIOD_LAST = c_REP_W'(REPEAT_PERIOD_CYCLES - 1);

    logic [NUM_KEYS-1:0] w_held;
    logic [NUM_KEYS-1:0] w_press;
    logic [NUM_KEYS-1:0] w_repeat;
    logic [NUM_KEYS-1:0] w_event;
    logic [NUM_KEYS-1:0] w_grant;
    logic [NUM_KEYS-1:0] r_pending;
    logic [NUM_KEYS-1:0] r_pulse;
    logic [3:0]          w_pulsePad;

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_keys

            key_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clock      (clock),
                .resetApp   (resetApp),
                .keyRaw_n   (key_n[gi]),
                .keyHeld    (w_held[gi]),
                .pressEvent (w_press[gi])
            );

            logic [c_HOLD_W-1:0] r_state;
            logic [c_HOLD_W-1:0] w_stateNext;
            logic [c_REP_W-1:0]  r_count;
            logic [c_REP_W-1:0]  w_countNext;
            logic                w_repeatEvt;

            always_ff @(posedge clock) begin
                if (resetApp) begin
                    r_state <= c_HOLD_IDLE;
                    r_count <= '0;
                end else begin
                    r_state <= w_stateNext;
                    r_count <= w_countNext;
                end
            end

            always_comb begin
                w_stateNext = r_state;
                w_countNext = r_count;
                w_repeatEvt = 1'b0;
                if (!w_held[gi]) begin
                    // Release wins over any timer expiry in the same cycle.
                    w_stateNext = c_HOLD_IDLE;
                    w_countNext = '0;
                end else begin
                    case (r_state)
                        c_HOLD_IDLE: begin
                            if (w_press[gi]) begin
                                w_stateNext = c_HOLD_DELAY;
                                w_countNext = '0;
                            end
                        end
                        c_HOLD_DELAY: begin
                            if (r_count == c_DELAY_LAST) begin
                                w_stateNext = c_HOLD_REPEAT;
                                w_countNext = '0;
                                w_repeatEvt = 1'b1;
                            end else begin
                                w_countNext = r_count + c_REP_W'(1);
                            end
                        end
                        c_HOLD_REPEAT: begin
                            if (r_count == c_PERIOD_LAST) begin
                                w_countNext = '0;
                                w_repeatEvt = 1'b1;
                            end else begin
                                w_countNext = r_count + c_REP_W'(1);
                            end
                        end
                        default: begin
                            w_stateNext = c_HOLD_IDLE;
                            w_countNext = '0;
                        end
                    endcase
                end
            end

            assign w_repeat[gi] = w_repeatEvt;
        end
    endgenerate

    assign w_event = w_press | w_repeat;

    // Isolate the lowest set pending bit: Left has the highest priority.
    assign w_grant = r_pending & (~r_pending + NUM_KEYS'(1));

    always_ff @(posedge clock) begin
        if (resetApp) begin
            r_pending <= '0;
            r_pulse   <= '0;
        end else begin
            // OR-ing the new events after clearing the grant keeps a bit set
            // when an event lands on its own grant, yielding one more pulse.
            r_pending <= (r_pending & ~w_grant) | w_event;
            r_pulse   <= w_grant;
        end
    end

    // Pad to the four named outputs; absent keys read as never pulsing.
    assign w_pulsePad = 4'(r_pulse);

    assign KeyLeft  = w_pulsePad[c_KEY_LEFT];
    assign KeyUp    = w_pulsePad[c_KEY_UP];
    assign KeyDown  = w_pulsePad[c_KEY_DOWN];
    assign KeyRight = w_pulsePad[c_KEY_RIGHT];
    assign KeysHeld = w_held;

endmodule : key_debounce_pulser
`default_nettype wire

// File: tb/tb_key_debounce_pulser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_debounce_pulser
//  Description : Self-checking bench for key_debounce_pulser with short
//                timing (debounce 4, repeat delay 10, repeat period 5).
//                Stimulus pushes expected pulses (edge number, key) into a
//                queue; a monitor pops and compares whenever a pulse appears.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_key_debounce_pulser;

    localparam int c_DEB = 4;
    localparam int c_RD  = 10;
    localparam int c_RP  = 5;

    typedef struct {
        int cyc;
        int key;
    } exp_t;

    logic       clock;
    logic       resetApp;
    logic [3:0] key_n;
    logic       KeyLeft;
    logic       KeyUp;
    logic       KeyDown;
    logic       KeyRight;
    logic [3:0] KeysHeld;

    int   cyc;
    int   total;
    int   bad;
    exp_t expQ[$];

    key_debounce_pulser #(
        .NUM_KEYS             (4),
        .DEBOUNCE_CYCLES      (c_DEB),
        .REPEAT_DELAY_CYCLES  (c_RD),
        .REPEAT_PERIOD_CYCLES (c_RP)
    ) dut (
        .clock    (clock),
        .resetApp (resetApp),
        .key_n    (key_n),
        .KeyLeft  (KeyLeft),
        .KeyUp    (KeyUp),
        .KeyDown  (KeyDown),
        .KeyRight (KeyRight),
        .KeysHeld (KeysHeld)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // cyc = number of rising edges so far; at a falling edge it names the
    // edge that launched the values currently on the outputs.
    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic expectPulse(input int c, input int k);
        exp_t e;
        e.cyc = c;
        e.key = k;
        expQ.push_back(e);
    endtask

    task automatic waitCyc(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0d, want %0d", name, cyc, act, req);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clock) begin
        logic [3:0] p;
        logic [3:0] want;
        exp_t       e;
        p = {KeyRight, KeyDown, KeyUp, KeyLeft};
        while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL missing_pulse: got none by edge %0d, want key %0d after edge %0d",
                     cyc, expQ[0].key, expQ[0].cyc);
            void'(expQ.pop_front());
        end
        if (p != 4'b0000) begin
            total++;
            if ($countones(p) != 1) begin
                bad++;
                $display("FAIL onehot at edge %0d: got pulses %b, want one-hot", cyc, p);
            end
            total++;
            if (expQ.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse at edge %0d: got %b, want none", cyc, p);
            end else begin
                e    = expQ.pop_front();
                want = 4'b0001 << e.key;
                if (e.cyc != cyc || p != want) begin
                    bad++;
                    $display("FAIL pulse: got %b after edge %0d, want %b after edge %0d",
                             p, cyc, want, e.cyc);
                end
            end
        end
    end

    initial begin
        total    = 0;
        bad      = 0;
        resetApp = 1'b1;
        key_n    = 4'hF;

        // Reset state.
        waitCyc(2);
        check("reset_held", int'(KeysHeld), 0);
        check("reset_pulses", int'({KeyRight, KeyDown, KeyUp, KeyLeft}), 0);
        waitCyc(3);
        resetApp = 1'b0;

        // Clean Left press first sampled at edge 10; release sampled at edge
        // 20 debounces at 25, exactly when the first repeat would have fired.
        waitCyc(9);
        key_n[0] = 1'b0;
        expectPulse(17, 0);
        waitCyc(14);
        check("left_held_before", int'(KeysHeld[0]), 0);
        waitCyc(15);
        check("left_held_after", int'(KeysHeld[0]), 1);
        waitCyc(19);
        key_n[0] = 1'b1;
        waitCyc(24);
        check("left_still_held", int'(KeysHeld[0]), 1);
        waitCyc(25);
        check("left_released", int'(KeysHeld[0]), 0);

        // Right bounce: low for 3 sampled edges only.
        waitCyc(34);
        key_n[3] = 1'b0;
        waitCyc(37);
        key_n[3] = 1'b1;
        for (int c = 36; c <= 45; c++) begin
            waitCyc(c);
            check("bounce_held", int'(KeysHeld), 0);
        end

        // Up held 40 cycles (edges 50..89): press, +10, then every 5.
        waitCyc(49);
        key_n[1] = 1'b0;
        expectPulse(57, 1);
        expectPulse(67, 1);
        expectPulse(72, 1);
        expectPulse(77, 1);
        expectPulse(82, 1);
        expectPulse(87, 1);
        expectPulse(92, 1);
        waitCyc(89);
        key_n[1] = 1'b1;
        waitCyc(95);
        check("up_released", int'(KeysHeld[1]), 0);

        // Left and Right on the same edge: Left first, Right one cycle later.
        waitCyc(109);
        key_n[0] = 1'b0;
        key_n[3] = 1'b0;
        expectPulse(117, 0);
        expectPulse(118, 3);
        waitCyc(114);
        key_n[0] = 1'b1;
        key_n[3] = 1'b1;
        waitCyc(115);
        check("simul_held", int'(KeysHeld), 9);

        // Down held into REPEAT; reset at edge 166 drops the repeat event
        // that would have pulsed at 167, then the key is re-debounced.
        waitCyc(139);
        key_n[2] = 1'b0;
        expectPulse(147, 2);
        expectPulse(157, 2);
        expectPulse(162, 2);
        expectPulse(174, 2);
        waitCyc(165);
        resetApp = 1'b1;
        waitCyc(166);
        resetApp = 1'b0;
        check("midreset_held", int'(KeysHeld), 0);
        waitCyc(171);
        check("redebounce_before", int'(KeysHeld[2]), 0);
        waitCyc(172);
        check("redebounce_after", int'(KeysHeld[2]), 1);
        waitCyc(176);
        key_n[2] = 1'b1;

        waitCyc(200);
        check("queue_drained", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_key_debounce_pulser
`default_nettype wire

// File: doc/key_debounce_pulser.md
KEY_DEBOUNCE_PULSER -- requirements
Module: key_debounce_pulser

Interface
REQ-001 Parameter NUM_KEYS, default 4: number of directional keys; bit order 0=Left, 1=Up, 2=Down, 3=Right.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles needed to accept a level change (20 ms at 50 MHz).
REQ-003 Parameter REPEAT_DELAY_CYCLES, default 25000000: hold time from accepted press to first auto-repeat.
REQ-004 Parameter REPEAT_PERIOD_CYCLES, default 10000000: interval between later auto-repeats.
REQ-005 clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 resetApp  input  1  reset; synchronous, active-high.
REQ-007 key_n  input  NUM_KEYS  raw push-button levels, active-low, asynchronous to clock.
REQ-008 KeyLeft, KeyUp, KeyDown, KeyRight  output  1 each  registered one-cycle move pulses, active-high, at most one high per cycle.
REQ-009 KeysHeld  output  NUM_KEYS  registered debounced pressed state per key, active-high.

Function
REQ-010 Each key_n bit SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-011 Per key, a debounce counter SHALL increment while the synchronized level differs from the debounced state.
REQ-012 The counter SHALL clear when the synchronized level equals the debounced state.
REQ-013 When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced state SHALL flip and the counter SHALL clear.
REQ-014 A released-to-pressed flip SHALL raise a press event for that key.
REQ-015 A pressed-to-released flip SHALL raise no event.
REQ-016 Per-key hold FSM states: IDLE, DELAY, REPEAT.
REQ-017 IDLE->DELAY on a press event; the repeat counter SHALL load 0.
REQ-018 DELAY->REPEAT when the counter reaches REPEAT_DELAY_CYCLES-1; this SHALL raise a repeat event and clear the counter.
REQ-019 In REPEAT, each time the counter reaches REPEAT_PERIOD_CYCLES-1, the FSM SHALL raise a repeat event and clear the counter.
REQ-020 Any state SHALL go to IDLE in the cycle the debounced state becomes released; no event is raised.
REQ-021 Press and repeat events SHALL set that key's pending bit.
REQ-022 A new event for a key whose pending bit is already set SHALL be merged, not queued.
REQ-023 Each cycle, the arbiter SHALL emit a pulse for the lowest-index pending key (Left>Up>Down>Right) and clear only that pending bit.
REQ-024 Other pending keys SHALL wait, one pulse per cycle.
REQ-025 If an event and its own grant coincide, the pending bit SHALL stay set, giving exactly one further pulse.
REQ-026 Latency: with a clean press first sampled at edge E0 and no contention, the pulse SHALL be high for exactly the cycle after edge E0+DEBOUNCE_CYCLES+3.
REQ-027 A bounce shorter than DEBOUNCE_CYCLES SHALL produce no pulse and no KeysHeld change.
REQ-028 Counters SHALL be sized to hold the largest parameter value and SHALL never wrap: they clear before overflow.

Reset
REQ-029 While resetApp is high at an edge, SHALL clear: synchronizer flops and debounced states (to released), all counters, pending bits, all pulse outputs and KeysHeld; all FSMs SHALL go to IDLE.
REQ-030 A key held through reset release SHALL be treated as a new press: it is debounced again and emits one pulse.
REQ-031 Reset during DELAY or REPEAT SHALL discard any pending pulse; no pulse is emitted in the cycle after reset deasserts.

Structure
REQ-032 Shared package/include SHALL hold: key index constants (KEY_LEFT=0 .. KEY_RIGHT=3), hold-FSM state encodings, default timing constants.
REQ-033 Sub-module key_debounce SHALL contain one key's synchronizer, debounce counter and edge detect.
REQ-034 key_debounce SHALL be instantiated NUM_KEYS times; the hold FSMs and arbiter SHALL live in the top module.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_PERIOD_CYCLES=5)
REQ-035 Clean press: key_n[0] low from edge 10 -> KeyLeft high only in the cycle after edge 17; KeysHeld[0]=1 from edge 15.
REQ-036 Bounce: key_n[3] low for 3 cycles, then high -> no KeyRight pulse and KeysHeld stays 0.
REQ-037 Auto-repeat: Up held 40 cycles -> first KeyUp pulse, second pulse 10 cycles later, then pulses every 5 cycles; none after release is debounced.
REQ-038 Simultaneous: Left and Right pressed on the same edge -> KeyLeft in cycle N, KeyRight in cycle N+1; never both high together.
REQ-039 Reset mid-hold: resetApp high 1 cycle during Down REPEAT with key still held -> no pulse for 6 cycles after deassert, then one KeyDown pulse (re-debounced press).
